// File: rtl/mem_responder.sv
// Data-memory responder: services one load/store at a time from an internal 64-bit doubleword SRAM.
// Latency: resp_valid is visible LATENCY+1 cycles after the accept edge; next accept follows the response handshake.
// Backpressure: req_ready stays low while busy; the response is held stable until resp_ready is seen high.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;

  logic [63:0] mem [0:(2**DEPTH_LOG2)-1];

  // The request being committed: live inputs when LATENCY is 0 (commit on the accept edge), else the latched copy.
  logic                  c_wr;
  logic [1:0]            c_size;
  logic [63:0]           c_addr;
  logic [63:0]           c_wdata;
  logic [63:0]           dw_off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  misal;
  logic                  err_d;
  logic [7:0]            mask_d;
  logic [63:0]           rdata_d;
  logic                  accept;
  logic                  commit;

  assign accept = (state_q == S_IDLE) && req_valid;
  assign commit = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign c_wr    = (state_q == S_IDLE) ? req_wr    : wr_q;
  assign c_size  = (state_q == S_IDLE) ? req_size  : size_q;
  assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  // Decode the committing access: doubleword index, range/alignment errors, byte-lane mask and read data.
  always_comb begin
    dw_off = (c_addr - BASE_ADDR) >> 3;
    idx    = dw_off[DEPTH_LOG2-1:0];
    case (c_size)
      2'b01:   misal = c_addr[0];
      2'b10:   misal = |c_addr[1:0];
      2'b11:   misal = |c_addr[2:0];
      default: misal = 1'b0;
    endcase
    err_d = (c_addr < BASE_ADDR) || (|dw_off[63:DEPTH_LOG2]) || misal;
    case (c_size)
      2'b00:   mask_d = 8'h01 << c_addr[2:0];
      2'b01:   mask_d = 8'h03 << {c_addr[2:1], 1'b0};
      2'b10:   mask_d = c_addr[2] ? 8'hF0 : 8'h0F;
      default: mask_d = 8'hFF;
    endcase
    rdata_d = (c_wr || err_d) ? 64'd0 : mem[idx];
  end

  // Byte-masked store on the commit edge; storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (commit && c_wr && !err_d) begin
      for (int b = 0; b < 8; b++) begin
        if (mask_d[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  // Request/response state machine with registered handshake and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wr_q        <= req_wr;
            size_q      <= req_size;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            cnt_q       <= 4'(LATENCY);
            if (LATENCY == 0) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= err_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q      <= S_RESP;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: random and directed loads/stores against a byte-level memory model.
// Main instance uses LATENCY=2; a second LATENCY=0 instance checks back-to-back throughput.
// Responses are back-pressured for random spans while stray requests are pulsed.
module tb_mem_responder;

  localparam int unsigned LAT  = 2;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  logic        req_valid0 = 1'b0, req_wr0 = 1'b0, resp_ready0 = 1'b1;
  logic [1:0]  req_size0 = 2'b11;
  logic [63:0] req_addr0 = 64'd0, req_wdata0 = 64'd0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [63:0] resp_rdata0;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_mem [1024];

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0), .req_size(req_size0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory: an access of 2^size bytes at a byte address; errors leave memory untouched.
  task automatic model(input bit wr, input bit [1:0] sz, input bit [63:0] a, input bit [63:0] wd,
                       output bit err, output bit [63:0] rd);
    int n;
    int idx;
    int lane;
    n   = 1 << sz;
    err = (a < BASE) || (((a - BASE) >> 3) >= 64'd1024) || ((a & 64'(n - 1)) != 64'd0);
    rd  = 64'd0;
    if (!err) begin
      idx = int'((a - BASE) >> 3);
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          lane = int'(a[2:0]) + i;
          ref_mem[idx][8*lane +: 8] = wd[8*lane +: 8];
        end
      end else begin
        rd = ref_mem[idx];
      end
    end
  endtask

  task automatic do_req(input bit wr, input bit [1:0] sz, input bit [63:0] a, input bit [63:0] wd,
                        input int hold, output bit [63:0] rd_seen);
    bit          exp_err;
    bit [63:0]   exp_rd;
    int          cyc;
    logic [63:0] held;
    model(wr, sz, a, wd, exp_err, exp_rd);
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    cyc = 0;
    while (cyc <= 20) begin
      @(negedge clock);
      cyc++;
      if (resp_valid === 1'b1) break;
      chk("busy_req_ready", req_ready, 0);
    end
    chk("latency", 64'(cyc), 64'(LAT + 1));
    chk("resp_err", resp_err, exp_err);
    chk("resp_rdata", resp_rdata, exp_rd);
    rd_seen = resp_rdata;
    held    = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b11; req_addr = BASE; req_wdata = {$urandom, $urandom};
      @(negedge clock);
      chk("bp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, held);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    @(negedge clock);
    chk("post_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_rdata", resp_rdata, 0);
    chk("post_err", resp_err, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [63:0] rd;
    bit [63:0] a;
    int        nresp;
    bit        exp_v;

    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b0;

    // Give the first 16 doublewords and the top one known contents.
    for (int i = 0; i < 16; i++) do_req(1, 2'b11, BASE + 64'(8 * i), {$urandom, $urandom}, 0, rd);
    do_req(1, 2'b11, BASE + 64'h1FF8, 64'hA5A5_0102_0304_5A5A, 0, rd);
    do_req(0, 2'b11, BASE + 64'h1FF8, 64'd0, 0, rd);

    do_req(1, 2'b11, BASE + 64'h10, 64'h1122_3344_5566_7788, 0, rd);
    do_req(0, 2'b11, BASE + 64'h10, 64'd0, 0, rd);
    chk("d_load_const", rd, 64'h1122_3344_5566_7788);
    do_req(1, 2'b00, BASE + 64'h15, 64'h0000_AB00_0000_0000, 0, rd);
    do_req(0, 2'b11, BASE + 64'h10, 64'd0, 0, rd);
    chk("b_merge_const", rd, 64'h1122_AB44_5566_7788);
    do_req(0, 2'b11, BASE + 64'h10, 64'd0, 5, rd);

    do_req(0, 2'b10, BASE + 64'h2, 64'd0, 0, rd);
    do_req(1, 2'b11, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd);
    do_req(0, 2'b11, BASE, 64'd0, 0, rd);
    do_req(0, 2'b11, BASE + 64'h2000, 64'd0, 0, rd);
    do_req(1, 2'b00, BASE + 64'h2000, 64'hFF, 0, rd);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'd8;
        1:       a = BASE + 64'h2000;
        default: a = BASE + 64'(8 * $urandom_range(0, 15));
      endcase
      a = a + 64'($urandom_range(0, 7));
      do_req(1'($urandom), 2'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 3), rd);
    end

    // Reset while a store waits: the store must never land.
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b11; req_addr = BASE + 64'h20; req_wdata = '1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_resp_rdata", resp_rdata, 0);
    chk("rstw_resp_err", resp_err, 0);
    @(negedge clock);
    reset = 1'b0;
    do_req(0, 2'b11, BASE + 64'h20, 64'd0, 0, rd);

    // Reset while a response is presented drops it at once.
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b11; req_addr = BASE + 64'h8;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (LAT + 1) @(negedge clock);
    chk("rstr_valid_before", resp_valid, 1);
    reset = 1'b1;
    #1;
    chk("rstr_resp_valid", resp_valid, 0);
    chk("rstr_req_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;

    // LATENCY=0 instance: back-to-back stores with resp_ready tied high.
    @(negedge clock);
    req_valid0 = 1'b1; req_wr0 = 1'b1; req_size0 = 2'b11; req_addr0 = BASE + 64'h8;
    req_wdata0 = 64'hCAFE_F00D_DEAD_BEEF;
    nresp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      exp_v = (c % 2 == 0);
      chk("l0_valid", resp_valid0, exp_v);
      chk("l0_req_ready", req_ready0, !exp_v);
      if (resp_valid0 === 1'b1) begin
        nresp++;
        chk("l0_err", resp_err0, 0);
      end
    end
    chk("l0_count", 64'(nresp), 64'd5);
    req_valid0 = 1'b0;
    @(negedge clock);
    req_valid0 = 1'b1; req_wr0 = 1'b0;
    @(posedge clock); #1;
    req_valid0 = 1'b0;
    @(negedge clock);
    chk("l0_load_valid", resp_valid0, 1);
    chk("l0_load_rdata", resp_rdata0, 64'hCAFE_F00D_DEAD_BEEF);
    chk("l0_load_err", resp_err0, 0);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
